float_result_bcd: RTL and testbench

Downstream of `float_adder`, this block takes one `result_integer`/`result_decimal` pair through a valid/ready handshake. It converts each field's two's-complement value to a sign flag plus packed BCD magnitude using an iterative shift-and-add-3 (double-dabble) sequence, one bit per cycle. The result drives the display/print path, replacing software `%0d.%0d` formatting.

---
 rtl/float_result_bcd.sv | 131 +++++++++++++
 tb/tb_float_result_bcd.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/float_result_bcd.sv
// float_result_bcd: converts a signed integer/decimal result pair into sign
// flags plus packed BCD magnitudes, using a one-bit-per-cycle double-dabble.
// The integer and decimal fields share one step counter. The integer path
// stops once its own bits are consumed.
module float_result_bcd #(
    parameter int INTEGER_WIDTH = 8,
    parameter int DECIMAL_WIDTH = 23,
    parameter int INT_DIGITS    = 3,
    parameter int DEC_DIGITS    = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INTEGER_WIDTH-1:0]  result_integer,
    input  logic [DECIMAL_WIDTH-1:0]  result_decimal,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_int_negative,
    output logic                      out_dec_negative,
    output logic [4*INT_DIGITS-1:0]   out_int_bcd,
    output logic [4*DEC_DIGITS-1:0]   out_dec_bcd
);

    localparam int N  = (INTEGER_WIDTH > DECIMAL_WIDTH) ? INTEGER_WIDTH : DECIMAL_WIDTH;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
    localparam logic [CW-1:0] INT_STEPS = CW'(INTEGER_WIDTH);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [INTEGER_WIDTH-1:0]   int_mag_q, int_mag_d;
    logic [DECIMAL_WIDTH-1:0]   dec_mag_q, dec_mag_d;
    logic [4*INT_DIGITS-1:0]    int_bcd_q, int_bcd_d;
    logic [4*DEC_DIGITS-1:0]    dec_bcd_q, dec_bcd_d;
    logic                       int_neg_q, int_neg_d;
    logic                       dec_neg_q, dec_neg_d;

    logic [4*INT_DIGITS-1:0]    int_adj;
    logic [4*DEC_DIGITS-1:0]    dec_adj;

    assign in_ready         = (state_q == IDLE) && rst_n;
    assign out_valid        = (state_q == DONE);
    assign out_int_negative = int_neg_q;
    assign out_dec_negative = dec_neg_q;
    assign out_int_bcd      = int_bcd_q;
    assign out_dec_bcd      = dec_bcd_q;

    // Add-3 correction: every BCD digit >= 5 is bumped so that the next shift carries correctly.
    always_comb begin
        int_adj = int_bcd_q;
        dec_adj = dec_bcd_q;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (int_bcd_q[4*i +: 4] >= 4'd5)
                int_adj[4*i +: 4] = int_bcd_q[4*i +: 4] + 4'd3;
        end
        for (int j = 0; j < DEC_DIGITS; j++) begin
            if (dec_bcd_q[4*j +: 4] >= 4'd5)
                dec_adj[4*j +: 4] = dec_bcd_q[4*j +: 4] + 4'd3;
        end
    end

    // Next-state logic: accept a pair in IDLE, run N shift steps, hold the result until it is taken.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        int_mag_d = int_mag_q;
        dec_mag_d = dec_mag_q;
        int_bcd_d = int_bcd_q;
        dec_bcd_d = dec_bcd_q;
        int_neg_d = int_neg_q;
        dec_neg_d = dec_neg_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    int_neg_d = result_integer[INTEGER_WIDTH-1];
                    dec_neg_d = result_decimal[DECIMAL_WIDTH-1];
                    // Unsigned negation of the most negative value yields its true magnitude.
                    int_mag_d = result_integer[INTEGER_WIDTH-1] ? -result_integer : result_integer;
                    dec_mag_d = result_decimal[DECIMAL_WIDTH-1] ? -result_decimal : result_decimal;
                    int_bcd_d = '0;
                    dec_bcd_d = '0;
                    cnt_d     = '0;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                dec_bcd_d = {dec_adj[4*DEC_DIGITS-2:0], dec_mag_q[DECIMAL_WIDTH-1]};
                dec_mag_d = {dec_mag_q[DECIMAL_WIDTH-2:0], 1'b0};
                if (cnt_q < INT_STEPS) begin
                    int_bcd_d = {int_adj[4*INT_DIGITS-2:0], int_mag_q[INTEGER_WIDTH-1]};
                    int_mag_d = {int_mag_q[INTEGER_WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            int_mag_q <= '0;
            dec_mag_q <= '0;
            int_bcd_q <= '0;
            dec_bcd_q <= '0;
            int_neg_q <= 1'b0;
            dec_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            int_mag_q <= int_mag_d;
            dec_mag_q <= dec_mag_d;
            int_bcd_q <= int_bcd_d;
            dec_bcd_q <= dec_bcd_d;
            int_neg_q <= int_neg_d;
            dec_neg_q <= dec_neg_d;
        end
    end

endmodule

// File: tb/tb_float_result_bcd.sv
// Directed bench for float_result_bcd with default parameters.
module tb_float_result_bcd;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  result_integer;
    logic [22:0] result_decimal;
    logic        out_valid;
    logic        out_ready;
    logic        out_int_negative;
    logic        out_dec_negative;
    logic [11:0] out_int_bcd;
    logic [27:0] out_dec_bcd;

    int pass_cnt;
    int total_cnt;

    float_result_bcd dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .result_integer   (result_integer),
        .result_decimal   (result_decimal),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_int_negative (out_int_negative),
        .out_dec_negative (out_dec_negative),
        .out_int_bcd      (out_int_bcd),
        .out_dec_bcd      (out_dec_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a pair for one accept edge, then drop in_valid (called from a negedge, block idle).
    task automatic send_pair(input logic [7:0] iv, input logic [22:0] dv);
        in_valid       = 1'b1;
        result_integer = iv;
        result_decimal = dv;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count negedges from just after the accept edge until out_valid; -1 if it never comes.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        result_integer = '0; result_decimal = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_int_negative !== 1'b0 ||
            out_dec_negative !== 1'b0 || out_int_bcd !== 12'h0 || out_dec_bcd !== 28'h0)
            $display("FAIL reset_state: rdy=%b vld=%b in=%b dn=%b ib=%h db=%h, want all 0",
                     in_ready, out_valid, out_int_negative, out_dec_negative, out_int_bcd, out_dec_bcd);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        send_pair(8'd6, 23'd2);
        wait_valid(n);
        total_cnt++;
        if (n !== 23) $display("FAIL basic_latency: got %0d want 23", n);
        else pass_cnt++;
        total_cnt++;
        if (out_int_bcd !== 12'h006 || out_dec_bcd !== 28'h0000002 ||
            out_int_negative !== 1'b0 || out_dec_negative !== 1'b0)
            $display("FAIL basic_value: ib=%h db=%h in=%b dn=%b want 006 0000002 0 0",
                     out_int_bcd, out_dec_bcd, out_int_negative, out_dec_negative);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL basic_after_hs: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_min_int();
        int n;
        send_pair(8'h80, 23'h000000);
        wait_valid(n);
        total_cnt++;
        if (n !== 23 || out_int_negative !== 1'b1 || out_int_bcd !== 12'h128 ||
            out_dec_negative !== 1'b0 || out_dec_bcd !== 28'h0)
            $display("FAIL min_int: n=%0d in=%b ib=%h dn=%b db=%h want 23 1 128 0 0",
                     n, out_int_negative, out_int_bcd, out_dec_negative, out_dec_bcd);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_dec_bounds();
        int n;
        send_pair(8'h7F, 23'h3FFFFF);
        wait_valid(n);
        total_cnt++;
        if (n !== 23 || out_dec_bcd !== 28'h4194303 || out_dec_negative !== 1'b0 ||
            out_int_bcd !== 12'h127 || out_int_negative !== 1'b0)
            $display("FAIL dec_max_pos: n=%0d db=%h dn=%b ib=%h in=%b want 23 4194303 0 127 0",
                     n, out_dec_bcd, out_dec_negative, out_int_bcd, out_int_negative);
        else pass_cnt++;
        @(negedge clk);
        send_pair(8'h7F, 23'h400000);
        wait_valid(n);
        total_cnt++;
        if (n !== 23 || out_dec_bcd !== 28'h4194304 || out_dec_negative !== 1'b1 ||
            out_int_bcd !== 12'h127 || out_int_negative !== 1'b0)
            $display("FAIL dec_min_neg: n=%0d db=%h dn=%b ib=%h in=%b want 23 4194304 1 127 0",
                     n, out_dec_bcd, out_dec_negative, out_int_bcd, out_int_negative);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        send_pair(8'd12, 23'd34);
        wait_valid(n);
        total_cnt++;
        if (n !== 23) $display("FAIL bp_latency: got %0d want 23", n);
        else pass_cnt++;
        in_valid = 1'b1; result_integer = 8'd56; result_decimal = 23'd78;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_int_bcd !== 12'h012 || out_dec_bcd !== 28'h0000034)
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b ib=%h db=%h want 1 0 012 0000034",
                         k, out_valid, in_ready, out_int_bcd, out_dec_bcd);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_next_accept: rdy=%b want 0", in_ready);
        else pass_cnt++;
        in_valid = 1'b0;
        wait_valid(n);
        total_cnt++;
        if (n !== 23 || out_int_bcd !== 12'h056 || out_dec_bcd !== 28'h0000078)
            $display("FAIL bp_second: n=%0d ib=%h db=%h want 23 056 0000078",
                     n, out_int_bcd, out_dec_bcd);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int  n;
        logic seen;
        send_pair(8'd5, 23'd5);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        seen  = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_int_bcd !== 12'h0 || out_dec_bcd !== 28'h0 || out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL midreset_clear: ib=%h db=%h vld=%b rdy=%b want 0 0 0 0",
                     out_int_bcd, out_dec_bcd, out_valid, in_ready);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (seen !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL midreset_no_valid: seen=%b rdy=%b want 0 1", seen, in_ready);
        else pass_cnt++;
        send_pair(8'd99, 23'd99);
        wait_valid(n);
        total_cnt++;
        if (n !== 23 || out_int_bcd !== 12'h099 || out_dec_bcd !== 28'h0000099)
            $display("FAIL midreset_after: n=%0d ib=%h db=%h want 23 099 0000099",
                     n, out_int_bcd, out_dec_bcd);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        out_ready = 1'b1;
        in_valid = 1'b1; result_integer = 8'hFB; result_decimal = 23'd1000;
        @(negedge clk);
        result_integer = 8'd42; result_decimal = 23'h7FFFF9;
        wait_valid(n);
        total_cnt++;
        if (n !== 23 || out_int_negative !== 1'b1 || out_int_bcd !== 12'h005 ||
            out_dec_negative !== 1'b0 || out_dec_bcd !== 28'h0001000 || in_ready !== 1'b0)
            $display("FAIL b2b_first: n=%0d in=%b ib=%h dn=%b db=%h rdy=%b want 23 1 005 0 0001000 0",
                     n, out_int_negative, out_int_bcd, out_dec_negative, out_dec_bcd, in_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL b2b_gap: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL b2b_accept: rdy=%b want 0", in_ready);
        else pass_cnt++;
        in_valid = 1'b0;
        wait_valid(n);
        total_cnt++;
        if (n !== 23 || out_int_negative !== 1'b0 || out_int_bcd !== 12'h042 ||
            out_dec_negative !== 1'b1 || out_dec_bcd !== 28'h0000007)
            $display("FAIL b2b_second: n=%0d in=%b ib=%h dn=%b db=%h want 23 0 042 1 0000007",
                     n, out_int_negative, out_int_bcd, out_dec_negative, out_dec_bcd);
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_min_int();
        test_dec_bounds();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
